// File: rtl/store_merge_rmw.sv
// store_merge_rmw: CPU store path into a word-wide, word-addressed data memory.
// Word stores are written directly. Halfword and byte stores read the word,
// merge the new lane(s) little-endian, then write the word back.
// Optional feature macro: STORE_MISALIGN_TRAP_EN. When it is defined, a misaligned
// word or halfword store is accepted but produces a one-cycle err pulse and no
// memory access. When it is undefined, the offset is ignored as described below
// and err is tied low.
module store_merge_rmw #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_TRAP = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         size_q, size_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               is_word_s;
    logic               misaligned_s;
    logic               unused_addr_s;

    // Address bits above the memory's word index do not take part in the store.
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    // Replace the addressed lane(s) of the old word with right-justified store data.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_data,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] res;
        res = old_word;
        case (size)
            2'd1: begin
                if (off[1]) begin
                    res[31:16] = new_data[15:0];
                end else begin
                    res[15:0] = new_data[15:0];
                end
            end
            2'd2: begin
                case (off)
                    2'd0:    res[7:0]   = new_data[7:0];
                    2'd1:    res[15:8]  = new_data[7:0];
                    2'd2:    res[23:16] = new_data[7:0];
                    2'd3:    res[31:24] = new_data[7:0];
                    default: res        = old_word;
                endcase
            end
            default: res = new_data;
        endcase
        return res;
    endfunction

    // Classify the incoming request (word size codes 0 and 3) and its alignment.
    always_comb begin
        is_word_s    = (req_size == 2'd0) || (req_size == 2'd3);
        misaligned_s = 1'b0;
        if (is_word_s) begin
            misaligned_s = (req_addr[1:0] != 2'd0);
        end else if (req_size == 2'd1) begin
            misaligned_s = req_addr[0];
        end else begin
            misaligned_s = 1'b0;
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state, request latching and merge; strobes decoded from the next state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        data_d    = data_q;
        size_d    = size_q;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr[ADDR_W+1:2];
                    off_d  = req_addr[1:0];
                    data_d = req_data;
                    size_d = req_size;
`ifdef STORE_MISALIGN_TRAP_EN
                    if (misaligned_s) begin
                        state_d = S_TRAP;
                    end else if (is_word_s) begin
                        state_d   = S_WR;
                        wr_data_d = req_data;
                    end else begin
                        state_d = S_RD;
                    end
`else
                    if (is_word_s) begin
                        state_d   = S_WR;
                        wr_data_d = req_data;
                    end else begin
                        state_d = S_RD;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD:    state_d = S_WAIT;
            S_WAIT: begin
                wr_data_d = merge_lanes(mem_rd_data, data_q, size_q, off_q);
                state_d   = S_WR;
            end
            S_WR:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:  ready_d = 1'b1;
            S_RD:    rd_en_d = 1'b1;
            S_WR: begin
                wr_en_d = 1'b1;
                done_d  = 1'b1;
            end
`ifdef STORE_MISALIGN_TRAP_EN
            S_TRAP:  err_d   = 1'b1;
`endif
            default: ready_d = 1'b0;
        endcase
    end

    // State, request registers and registered output strobes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            off_q     <= 2'd0;
            data_q    <= 32'd0;
            size_q    <= 2'd0;
            wr_data_q <= 32'd0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            data_q    <= data_d;
            size_q    <= size_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    // Misalignment pulse register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign req_ready   = ready_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign done        = done_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: behavioural 1-cycle-latency memory, reference
// memory model, and a queue of expected memory transactions checked on negedges.
module tb_store_merge_rmw;

    localparam int ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_data = 32'd0;
    logic [1:0]        req_size = 2'd0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic              done;
    logic              err;

    store_merge_rmw #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // kind: 0 word write, 1 read-modify-write, 2 misalignment trap
    typedef struct {
        int          kind;
        logic [9:0]  idx;
        logic [31:0] data;
        int          start;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;
    exp_t q[$];

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_data = 32'd0;

    int n_vec = 0;
    int n_bad = 0;

    // Memory: preload port, write port, synchronous read with one cycle latency.
    always @(posedge Clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = 10'(idx); pl_data = d;
        ref_mem[idx] = d;
        @(negedge Clk);
        pl_en = 1'b0;
    endtask

    // Present one store, wait for acceptance, and record the expected transaction.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        exp_t e;
        int   n;
        int   idx;
        int   off;
        bit   mis;
        req_addr = a; req_data = d; req_size = sz; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        idx = int'(a[11:2]);
        off = int'(a[1:0]);
        mis = (sz == 2'd0 || sz == 2'd3) ? (off != 0) : (sz == 2'd1 && a[0]);
        e.idx = 10'(idx); e.start = cyc + 1; e.rd_cyc = -1; e.wr_cyc = cyc + 1; e.kind = 0;
`ifdef STORE_MISALIGN_TRAP_EN
        if (mis) e.kind = 2;
`else
        if (mis) e.kind = 0;
`endif
        if (e.kind != 2) begin
            if (sz == 2'd0 || sz == 2'd3) begin
                ref_mem[idx] = d;
            end else begin
                e.kind = 1; e.rd_cyc = cyc + 1; e.wr_cyc = cyc + 3;
                if (sz == 2'd1) ref_mem[idx][16*int'(a[1]) +: 16] = d[15:0];
                else            ref_mem[idx][8*off +: 8] = d[7:0];
            end
        end
        e.data = ref_mem[idx];
        q.push_back(e);
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (q.size() > 0) check("drain", 32'(q.size()), 32'd0);
    endtask

    // Monitor: compare DUT strobes against the front of the expectation queue.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (q.size() > 0 && cyc >= q[0].start && cyc <= q[0].wr_cyc)
                check("ready_busy", 32'(req_ready), 32'd0);
            if (done | mem_wr_en) check("done_with_wr", 32'(done), 32'(mem_wr_en));
            if (mem_rd_en) begin
                if (q.size() > 0) begin
                    check("rd_cycle", 32'(cyc), 32'(q[0].rd_cyc));
                    check("rd_addr", 32'(mem_addr), 32'(q[0].idx));
                end else check("rd_spurious", 32'd1, 32'd0);
            end
            if (err) begin
                if (q.size() > 0 && q[0].kind == 2) begin
                    check("err_cycle", 32'(cyc), 32'(q[0].wr_cyc));
                    void'(q.pop_front());
                end else check("err_spurious", 32'd1, 32'd0);
            end else if (mem_wr_en) begin
                if (q.size() > 0 && q[0].kind != 2) begin
                    check("wr_cycle", 32'(cyc), 32'(q[0].wr_cyc));
                    check("wr_addr", 32'(mem_addr), 32'(q[0].idx));
                    check("wr_data", mem_wr_data, q[0].data);
                    void'(q.pop_front());
                end else check("wr_spurious", 32'd1, 32'd0);
            end else if (q.size() > 0 && cyc > q[0].wr_cyc) begin
                check("missed_txn", 32'(cyc), 32'(q[0].wr_cyc));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sz_r;
        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 16; i++) preload(i, $urandom);

        // Word store
        preload(5, 32'hDEADBEEF);
        do_store(32'h0000_0014, 32'h12345678, 2'd0);
        drain();
        // Byte store into lane 2
        preload(3, 32'hAABBCCDD);
        do_store(32'h0000_000E, 32'hFFFFFF5A, 2'd2);
        drain();
        check("byte_mem", mem[3], 32'hAA5ACCDD);
        // Halfword stores, upper then lower lane on a fresh word
        preload(0, 32'h11223344);
        do_store(32'h0000_0002, 32'h0000BEEF, 2'd1);
        drain();
        check("half_hi_mem", mem[0], 32'hBEEF3344);
        preload(0, 32'h11223344);
        do_store(32'h0000_0000, 32'h0000BEEF, 2'd1);
        drain();
        check("half_lo_mem", mem[0], 32'h1122BEEF);
        // Back-to-back byte stores to the same word
        preload(7, 32'h0);
        do_store(32'h0000_001C, 32'h00000001, 2'd2);
        do_store(32'h0000_001D, 32'h00000002, 2'd2);
        drain();
        check("b2b_mem", mem[7], 32'h00000201);
        // Upper address bits ignored, word index wraps
        do_store(32'hFFFF_F024, 32'hA5A5_0F0F, 2'd0);
        drain();
        // Misaligned word store
        do_store(32'h0000_0001, 32'hCAFEF00D, 2'd0);
        drain();
        // Random mix of sizes and offsets on words 0..15
        for (int i = 0; i < 24; i++) begin
            sz_r = $urandom_range(3, 0);
            do_store(($urandom & 32'hFFFF_F03F), $urandom, sz_r[1:0]);
        end
        drain();
        // Reset while waiting for read data
        preload(9, 32'h55AA55AA);
        do_store(32'h0000_0025, 32'h00000077, 2'd2);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wr_data", mem_wr_data, 32'd0);
        q.delete();
        ref_mem[9] = 32'h55AA55AA;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_mem", mem[9], 32'h55AA55AA);
        // Final memory image against the reference model
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Store-side counterpart to the load-data extender: takes a CPU store (word/halfword/byte) and writes it into a word-wide, word-addressed data memory.
- Sub-word stores use a read-modify-write sequence: read the word, merge the new lane(s), write back.
- Sits between the MEM-stage store path and the data memory's synchronous 1-cycle-latency read port / write port.

Parameters:
- ADDR_W, 10, word-address width of data memory (memory holds 2^ADDR_W 32-bit words).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block idle and accepting; transfer when req_valid & req_ready at a rising edge.
- req_addr  input  32  byte address of the store.
- req_data  input  32  store data; sub-word data is right-justified (byte in [7:0], half in [15:0]).
- req_size  input  2  0 = word, 1 = halfword, 2 = byte, 3 = word (same encoding as load-extend select).
- mem_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W+1:2] registered at accept.
- mem_rd_en  output  1  memory read strobe; data returns on mem_rd_data the following cycle.
- mem_rd_data  input  32  memory read data.
- mem_wr_en  output  1  memory write strobe, one cycle.
- mem_wr_data  output  32  full word to write.
- done  output  1  one-cycle pulse, coincident with mem_wr_en.
- err  output  1  one-cycle misalignment pulse (meaningful only with the optional feature).

Behaviour:
- Reset (asynchronous, Reset_n low): state IDLE; req_ready=1; mem_rd_en, mem_wr_en, done and err = 0; mem_addr and mem_wr_data = 0; internal address, data, size and offset registers cleared.
- A reset during any state aborts the operation. No write is issued and the request is dropped.
- States: IDLE, RD, WAIT, WR.
- IDLE:
  - req_ready=1.
  - On accept, latch the address (word index plus offset = req_addr[1:0]), data and size.
  - Word (size 0 or 3) goes to WR; mem_wr_data = req_data.
  - Halfword or byte goes to RD.
- RD: mem_rd_en=1 for exactly one cycle; go to WAIT.
- WAIT:
  - mem_rd_data is valid. Register the merged word; go to WR.
  - Byte: lane = offset; bits [8*off+7:8*off] = req_data[7:0]; all other bits come from mem_rd_data.
  - Halfword: lane = offset[1]; offset[1]=0 replaces [15:0], offset[1]=1 replaces [31:16]; other bits come from mem_rd_data.
  - Byte ordering is little-endian.
- WR: mem_wr_en=1 and done=1 for one cycle; go to IDLE.
- req_ready=0 in RD, WAIT and WR. Back-to-back requests are accepted on the cycle after WR.
- Latency from the accept edge T:
  - Word: write strobe during cycle T+1.
  - Sub-word: read strobe during T+1, merge during T+2, write strobe during T+3.
- mem_addr holds a stable value from T+1 until the next accept.
- When req_valid=0 in IDLE, all strobes stay 0 and the registers hold.
- Address bits above ADDR_W+1 are ignored. Word index wraps within the memory.
- Misalignment (without the optional feature):
  - Ignored. Word stores ignore offset.
  - Halfword uses offset[1] only.
  - err is tied to 0.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined:
  - A request is misaligned when it is a word store with offset ≠ 0, or a halfword store with offset[0] = 1.
  - A misaligned request is still accepted. The block pulses err=1 for the cycle after accept, issues no memory access, and returns to IDLE; done stays 0.
  - req_ready is low during that cycle.
- Undefined: err is constant 0 and misaligned requests are handled as described in Behaviour.

Test Plan:
- Word store: mem word 5 = 0xDEADBEEF; store addr 0x14, size 0, data 0x12345678 -> no mem_rd_en; mem_wr_en, done and mem_addr=5 one cycle after accept; mem_wr_data=0x12345678.
- Byte store: mem word 3 = 0xAABBCCDD; store addr 0x0E, size 2, data 0xFFFFFF5A -> mem_rd_en at T+1; mem_wr_data=0xAA5ACCDD at T+3; done at T+3.
- Halfword store: mem word 0 = 0x11223344; store addr 0x02, size 1, data 0x0000BEEF -> mem_wr_data=0xBEEF3344; store addr 0x00 on the same word -> 0x1122BEEF.
- Back-to-back: two byte stores to the same word (offsets 0 then 1, data 0x01 then 0x02, mem = 0) -> second read returns 0x00000001; final write is 0x00000201; req_ready low during busy cycles.
- Reset mid-operation: assert Reset_n=0 in WAIT -> outputs drop to 0 immediately; no mem_wr_en; req_ready=1 after release; memory unchanged.
- With STORE_MISALIGN_TRAP_EN: word store addr 0x01 -> err=1 for one cycle; no mem_rd_en or mem_wr_en; done=0. Without the macro: same stimulus writes word 0 with the full data.
